fab_mem_bel_dp: RTL and testbench

Parametrised dual-port memory BEL for eastern-edge memory tiles; successor to the single-port 32-bit Mem BEL. Port A reads and writes with byte enables, port B is read-only. Both ports use a valid/ready handshake and have a configurable read latency. After reset the block runs an internal zero-fill sweep, so fabric logic always starts from a known memory image. It is instantiated as a BEL inside a tile and clocked by the tile's UserCLK.

---
 rtl/fab_mem_bel_dp_pkg.sv | 26 ++
 rtl/fab_mem_bel_dp_if.sv | 43 ++++
 rtl/fab_mem_bel_dp_array.sv | 74 +++++++
 rtl/fab_mem_bel_dp.sv | 155 +++++++++++++++
 tb/tb_fab_mem_bel_dp.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fab_mem_bel_dp_pkg.sv
// Shared types and helpers for the dual-port memory BEL: FSM state encoding,
// read-during-write mode constants and the byte-lane merge used for writes
// and the new-data bypass.
package fab_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int BYTE_W = 8;

  // A word merge is built lane by lane from this, so it works for any
  // DATA_WIDTH that is a multiple of 8.
  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              en
  );
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/fab_mem_bel_dp_if.sv
// Fabric-side bundle of the dual-port memory BEL: port A read/write with byte
// enables, port B read-only, both valid/ready; plus the busy indication.
interface fab_mem_bel_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic                    a_valid;
  logic                    a_ready;
  logic                    a_write;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_wdata;
  logic [DATA_WIDTH/8-1:0] a_be;
  logic                    a_rvalid;
  logic [DATA_WIDTH-1:0]   a_rdata;

  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic                    b_rvalid;
  logic [DATA_WIDTH-1:0]   b_rdata;

  logic                    busy;

  // Fabric logic issuing requests
  modport master (
    output a_valid, a_write, a_addr, a_wdata, a_be,
    output b_valid, b_addr,
    input  a_ready, a_rvalid, a_rdata,
    input  b_ready, b_rvalid, b_rdata,
    input  busy
  );

  // The memory BEL serving them
  modport slave (
    input  a_valid, a_write, a_addr, a_wdata, a_be,
    input  b_valid, b_addr,
    output a_ready, a_rvalid, a_rdata,
    output b_ready, b_rvalid, b_rdata,
    output busy
  );

endinterface

// File: rtl/fab_mem_bel_dp_array.sv
// DEPTH x DATA_WIDTH storage with one byte-enabled write port and two
// synchronous read ports. Port A always sees the pre-write word; port B can
// optionally bypass the word being written in the same cycle.
module fab_mem_array
  import fab_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wbe,
  input  logic                    i_a_re,
  input  logic [ADDR_WIDTH-1:0]   i_a_raddr,
  output logic [DATA_WIDTH-1:0]   o_a_rdata,
  input  logic                    i_b_re,
  input  logic [ADDR_WIDTH-1:0]   i_b_raddr,
  output logic [DATA_WIDTH-1:0]   o_b_rdata
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH/8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_a_rdata_p1;
  logic [DATA_WIDTH-1:0] r_b_rdata_p1;
  logic [DATA_WIDTH-1:0] w_b_merged;
  logic                  w_b_bypass;

  // Byte-lane write: only enabled lanes of the addressed word change
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (i_wbe[i]) begin
          r_mem[i_waddr][BYTE_W*i +: BYTE_W] <= i_wdata[BYTE_W*i +: BYTE_W];
        end
      end
    end
  end

  // Word port B would see if the concurrent write had already landed
  always_comb begin
    w_b_merged = r_mem[i_b_raddr];
    for (int i = 0; i < NBYTES; i++) begin
      w_b_merged[BYTE_W*i +: BYTE_W] = merge_byte(r_mem[i_b_raddr][BYTE_W*i +: BYTE_W],
                                                  i_wdata[BYTE_W*i +: BYTE_W], i_wbe[i]);
    end
  end

  assign w_b_bypass = (RDW_MODE == RDW_NEW) && i_we && (i_waddr == i_b_raddr);

  // ---- stage p1: registered read data, held until the next read on that port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_rdata_p1 <= '0;
      r_b_rdata_p1 <= '0;
    end else begin
      if (i_a_re) begin
        r_a_rdata_p1 <= r_mem[i_a_raddr];
      end
      if (i_b_re) begin
        r_b_rdata_p1 <= w_b_bypass ? w_b_merged : r_mem[i_b_raddr];
      end
    end
  end

  assign o_a_rdata = r_a_rdata_p1;
  assign o_b_rdata = r_b_rdata_p1;

endmodule

// File: rtl/fab_mem_bel_dp.sv
// Dual-port memory BEL for eastern-edge memory tiles. Holds the post-reset
// zero-fill sweep, the write-port mux between sweep and port A, the
// valid/ready handshakes and the optional second read-data register stage.
module fab_mem_bel_dp
  import fab_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            UserCLK,
  input  logic            reset,
  fab_mem_bel_dp_if.slave bus
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int NBYTES = DATA_WIDTH/8;

  state_t                r_state;
  logic [CNT_W-1:0]      r_clr_cnt;

  logic                  w_run_ok;
  logic                  w_clr_we;
  logic                  w_clr_last;
  logic                  w_a_acc;
  logic                  w_b_acc;
  logic                  w_a_wr;
  logic                  w_a_rd;

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [NBYTES-1:0]     w_wbe;

  logic                  r_a_vld_p1;
  logic                  r_b_vld_p1;
  logic [DATA_WIDTH-1:0] w_a_rdata_p1;
  logic [DATA_WIDTH-1:0] w_b_rdata_p1;

  logic                  w_a_vld_out;
  logic                  w_b_vld_out;
  logic [DATA_WIDTH-1:0] w_a_rdata_out;
  logic [DATA_WIDTH-1:0] w_b_rdata_out;

  // Reset is combined in directly so nothing is accepted in a reset cycle
  assign w_run_ok   = (r_state == ST_RUN) && !reset;
  assign w_a_acc    = bus.a_valid && w_run_ok;
  assign w_b_acc    = bus.b_valid && w_run_ok;
  assign w_a_wr     = w_a_acc && bus.a_write;
  assign w_a_rd     = w_a_acc && !bus.a_write;

  // The counter is one bit wider than the address, so the terminal compare
  // never sees a wrapped value
  assign w_clr_we   = (r_state == ST_CLEAR) && !reset;
  assign w_clr_last = (r_clr_cnt == CNT_W'(DEPTH-1));

  // The sweep owns the write port while clearing; port A cannot be accepted then
  assign w_we    = w_clr_we || w_a_wr;
  assign w_waddr = w_clr_we ? r_clr_cnt[ADDR_WIDTH-1:0] : bus.a_addr;
  assign w_wdata = w_clr_we ? '0 : bus.a_wdata;
  assign w_wbe   = w_clr_we ? '1 : bus.a_be;

  // Clear-sweep FSM: reset restarts the sweep from address 0
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + CNT_W'(1);
      if (w_clr_last) begin
        r_state <= ST_RUN;
      end
    end
  end

  fab_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RDW_MODE   (RDW_MODE)
  ) u_array (
    .i_clk     (UserCLK),
    .i_rst     (reset),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_wbe     (w_wbe),
    .i_a_re    (w_a_rd),
    .i_a_raddr (bus.a_addr),
    .o_a_rdata (w_a_rdata_p1),
    .i_b_re    (w_b_acc),
    .i_b_raddr (bus.b_addr),
    .o_b_rdata (w_b_rdata_p1)
  );

  // ---- stage p1: read-accept valids, aligned with the array's data register
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_a_vld_p1 <= 1'b0;
      r_b_vld_p1 <= 1'b0;
    end else begin
      r_a_vld_p1 <= w_a_rd;
      r_b_vld_p1 <= w_b_acc;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_a_vld_p2;
    logic                  r_b_vld_p2;
    logic [DATA_WIDTH-1:0] r_a_rdata_p2;
    logic [DATA_WIDTH-1:0] r_b_rdata_p2;

    // ---- stage p2: extra output register; data only moves with a response
    always_ff @(posedge UserCLK) begin
      if (reset) begin
        r_a_vld_p2   <= 1'b0;
        r_b_vld_p2   <= 1'b0;
        r_a_rdata_p2 <= '0;
        r_b_rdata_p2 <= '0;
      end else begin
        r_a_vld_p2 <= r_a_vld_p1;
        r_b_vld_p2 <= r_b_vld_p1;
        if (r_a_vld_p1) begin
          r_a_rdata_p2 <= w_a_rdata_p1;
        end
        if (r_b_vld_p1) begin
          r_b_rdata_p2 <= w_b_rdata_p1;
        end
      end
    end

    assign w_a_vld_out   = r_a_vld_p2;
    assign w_b_vld_out   = r_b_vld_p2;
    assign w_a_rdata_out = r_a_rdata_p2;
    assign w_b_rdata_out = r_b_rdata_p2;
  end else begin : g_lat1
    assign w_a_vld_out   = r_a_vld_p1;
    assign w_b_vld_out   = r_b_vld_p1;
    assign w_a_rdata_out = w_a_rdata_p1;
    assign w_b_rdata_out = w_b_rdata_p1;
  end

  // Outputs read as their reset values for the whole time reset is high, so an
  // in-flight response is suppressed as soon as reset is raised
  assign bus.a_ready  = w_run_ok;
  assign bus.b_ready  = w_run_ok;
  assign bus.busy     = !w_run_ok;
  assign bus.a_rvalid = w_a_vld_out && !reset;
  assign bus.b_rvalid = w_b_vld_out && !reset;
  assign bus.a_rdata  = reset ? '0 : w_a_rdata_out;
  assign bus.b_rdata  = reset ? '0 : w_b_rdata_out;

endmodule

// File: tb/tb_fab_mem_bel_dp.sv
// Directed bench for fab_mem_bel_dp. Three instances share one stimulus:
//   u0: READ_LATENCY=1, RDW_MODE=0, CLEAR_ON_RESET=1
//   u1: READ_LATENCY=2, RDW_MODE=1, CLEAR_ON_RESET=1
//   u2: READ_LATENCY=1, RDW_MODE=0, CLEAR_ON_RESET=0
module tb_fab_mem_bel_dp;

  logic        clk = 1'b0;
  logic        t_rst;
  logic        t_a_valid;
  logic        t_a_write;
  logic [7:0]  t_a_addr;
  logic [31:0] t_a_wdata;
  logic [3:0]  t_a_be;
  logic        t_b_valid;
  logic [7:0]  t_b_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fab_mem_bel_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) if0 ();
  fab_mem_bel_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) if1 ();
  fab_mem_bel_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) if2 ();

  assign if0.a_valid = t_a_valid;
  assign if0.a_write = t_a_write;
  assign if0.a_addr  = t_a_addr;
  assign if0.a_wdata = t_a_wdata;
  assign if0.a_be    = t_a_be;
  assign if0.b_valid = t_b_valid;
  assign if0.b_addr  = t_b_addr;

  assign if1.a_valid = t_a_valid;
  assign if1.a_write = t_a_write;
  assign if1.a_addr  = t_a_addr;
  assign if1.a_wdata = t_a_wdata;
  assign if1.a_be    = t_a_be;
  assign if1.b_valid = t_b_valid;
  assign if1.b_addr  = t_b_addr;

  assign if2.a_valid = t_a_valid;
  assign if2.a_write = t_a_write;
  assign if2.a_addr  = t_a_addr;
  assign if2.a_wdata = t_a_wdata;
  assign if2.a_be    = t_a_be;
  assign if2.b_valid = t_b_valid;
  assign if2.b_addr  = t_b_addr;

  fab_mem_bel_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1),
                   .RDW_MODE(0), .CLEAR_ON_RESET(1))
    u0 (.UserCLK(clk), .reset(t_rst), .bus(if0));
  fab_mem_bel_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2),
                   .RDW_MODE(1), .CLEAR_ON_RESET(1))
    u1 (.UserCLK(clk), .reset(t_rst), .bus(if1));
  fab_mem_bel_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1),
                   .RDW_MODE(0), .CLEAR_ON_RESET(0))
    u2 (.UserCLK(clk), .reset(t_rst), .bus(if2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    t_a_valid = 1'b0;
    t_a_write = 1'b0;
    t_b_valid = 1'b0;
  endtask

  task automatic a_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    t_a_valid = 1'b1;
    t_a_write = 1'b1;
    t_a_addr  = addr;
    t_a_wdata = data;
    t_a_be    = be;
  endtask

  task automatic a_rd(input logic [7:0] addr);
    t_a_valid = 1'b1;
    t_a_write = 1'b0;
    t_a_addr  = addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rv_cnt;
    logic rv_seen;

    t_rst = 1'b1;
    idle();
    t_a_addr  = '0;
    t_a_wdata = '0;
    t_a_be    = '0;
    t_b_addr  = '0;

    // Reset for three cycles
    step(); step(); step();
    chk1("rst_a_ready", if0.a_ready, 1'b0);
    chk1("rst_b_ready", if0.b_ready, 1'b0);
    chk1("rst_busy", if0.busy, 1'b1);
    chk1("rst_a_rvalid", if0.a_rvalid, 1'b0);
    chk1("rst_b_rvalid", if1.b_rvalid, 1'b0);
    chk("rst_a_rdata", if0.a_rdata, 32'h0);
    chk("rst_b_rdata", if1.b_rdata, 32'h0);
    chk1("rst_noclr_busy", if2.busy, 1'b1);

    // Release: no-clear instance is ready at once, the others sweep
    t_rst = 1'b0;
    #1;
    chk1("noclr_ready", if2.a_ready, 1'b1);
    chk1("noclr_busy", if2.busy, 1'b0);
    n = 0;
    while (if0.busy && n < 400) begin
      n++;
      step();
    end
    chk("clr_busy_cycles", n, 32'd256);
    chk1("clr_a_ready", if0.a_ready, 1'b1);
    chk1("clr_b_ready_l2", if1.b_ready, 1'b1);

    // Stream reads over every address: all zero, one rvalid per accept
    rv_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      a_rd(8'(i));
      step();
      if (if0.a_rvalid) rv_cnt++;
      chk($sformatf("clr_rd_%0d", i), if0.a_rdata, 32'h0);
    end
    idle();
    chk("clr_rd_rvalid_count", rv_cnt, 32'd256);

    // Byte enables
    a_wr(8'd5, 32'hAABBCCDD, 4'b1111);
    step();
    chk1("wr_no_rvalid", if0.a_rvalid, 1'b0);
    a_wr(8'd5, 32'h11223344, 4'b0101);
    step();
    a_rd(8'd5);
    step();
    idle();
    chk1("be_rvalid_l1", if0.a_rvalid, 1'b1);
    chk("be_rdata_l1", if0.a_rdata, 32'hAA22CC44);
    chk1("be_rvalid_l2_early", if1.a_rvalid, 1'b0);
    step();
    chk1("be_rvalid_l1_pulse", if0.a_rvalid, 1'b0);
    chk("be_rdata_l1_hold", if0.a_rdata, 32'hAA22CC44);
    chk1("be_rvalid_l2", if1.a_rvalid, 1'b1);
    chk("be_rdata_l2", if1.a_rdata, 32'hAA22CC44);

    // Same-cycle collision on address 9 (holds zero)
    a_wr(8'd9, 32'hDEADBEEF, 4'b1111);
    t_b_valid = 1'b1;
    t_b_addr  = 8'd9;
    step();
    idle();
    chk1("col_b_rvalid_old", if0.b_rvalid, 1'b1);
    chk("col_b_rdata_old", if0.b_rdata, 32'h0);
    step();
    chk1("col_b_rvalid_new", if1.b_rvalid, 1'b1);
    chk("col_b_rdata_new", if1.b_rdata, 32'hDEADBEEF);

    // All-zero byte enables leave the word untouched
    a_wr(8'd9, 32'hFFFFFFFF, 4'b0000);
    step();
    a_rd(8'd9);
    step();
    idle();
    chk("be0_rdata", if0.a_rdata, 32'hDEADBEEF);

    // Preload 0..3 with 10..13, then stream port B reads
    for (int k = 0; k < 4; k++) begin
      a_wr(8'(k), 32'(10 + k), 4'b1111);
      step();
    end
    idle();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        t_b_valid = 1'b1;
        t_b_addr  = 8'(k);
      end else begin
        t_b_valid = 1'b0;
      end
      step();
      if (k < 4) begin
        chk($sformatf("stream_l1_data_%0d", k), if0.b_rdata, 32'(10 + k));
      end
      if (k == 0) begin
        chk1("stream_l2_rvalid_first", if1.b_rvalid, 1'b0);
      end else begin
        chk1($sformatf("stream_l2_rvalid_%0d", k), if1.b_rvalid, 1'b1);
        chk($sformatf("stream_l2_data_%0d", k), if1.b_rdata, 32'(9 + k));
      end
    end
    step();
    chk1("stream_l2_rvalid_end", if1.b_rvalid, 1'b0);

    // Reset while a port A read is in flight
    a_wr(8'd7, 32'h12345678, 4'b1111);
    step();
    a_rd(8'd7);
    step();
    t_rst = 1'b1;
    idle();
    #1;
    chk1("midrst_a_rvalid_l1", if0.a_rvalid, 1'b0);
    chk1("midrst_busy", if0.busy, 1'b1);
    chk1("midrst_a_ready", if0.a_ready, 1'b0);
    step();
    chk1("midrst_a_rvalid_l2", if1.a_rvalid, 1'b0);
    t_rst = 1'b0;
    #1;
    rv_seen = 1'b0;
    n = 0;
    while (if0.busy && n < 400) begin
      if (if0.a_rvalid || if1.a_rvalid) rv_seen = 1'b1;
      n++;
      step();
    end
    if (if0.a_rvalid || if1.a_rvalid) rv_seen = 1'b1;
    chk("midrst_busy_cycles", n, 32'd256);
    chk1("midrst_no_rvalid", rv_seen, 1'b0);
    a_rd(8'd7);
    t_b_valid = 1'b1;
    t_b_addr  = 8'd5;
    step();
    idle();
    chk("midrst_rd7", if0.a_rdata, 32'h0);
    chk("midrst_rd5", if0.b_rdata, 32'h0);
    step();
    chk("midrst_rd7_l2", if1.a_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
